// File: rtl/pcs_rx_lock_ctrl_pkg.sv
// Shared constants and types for the per-lane receive block-lock controller.
// Holds the sync header codes, default thresholds and the lock FSM state type.
package pcs_rx_lock_ctrl_pkg;

  localparam logic [1:0] SYNC_HEAD_DATA = 2'b01;
  localparam logic [1:0] SYNC_HEAD_CTRL = 2'b10;

  localparam int HEAD_W_DEF       = 2;
  localparam int SH_CNT_MAX_DEF   = 64;
  localparam int SH_INVLD_MAX_DEF = 16;
  localparam int SLIP_WAIT_N_DEF  = 4;

  typedef enum logic {
    LOCK_TEST      = 1'b0,
    LOCK_SLIP_WAIT = 1'b1
  } lock_state_e;

  // Only the two transition codes are legal; 00 and 11 indicate misalignment.
  function automatic logic sync_head_valid(input logic [1:0] head);
    return (head == SYNC_HEAD_DATA) || (head == SYNC_HEAD_CTRL);
  endfunction

endpackage

// File: rtl/pcs_rx_lock_ctrl.sv
// Per-lane block-lock FSM: evaluates 66b sync headers in fixed windows,
// declares lock and pulses a one-bit gearbox slip on misalignment.
//
// state          | meaning
// LOCK_TEST      | headers counted into the current window, lock decisions made
// LOCK_SLIP_WAIT | gearbox settling after a slip, valid blocks ignored
module pcs_rx_lock_ctrl
  import pcs_rx_lock_ctrl_pkg::*;
#(
  parameter int HEAD_W       = HEAD_W_DEF,
  parameter int SH_CNT_MAX   = SH_CNT_MAX_DEF,
  parameter int SH_INVLD_MAX = SH_INVLD_MAX_DEF,
  parameter int SLIP_WAIT_N  = SLIP_WAIT_N_DEF
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              serdes_v_i,
  input  logic [HEAD_W-1:0] serdes_head_i,
  output logic              gearbox_slip_o,
  output logic              lock_v_o,
  output logic              lock_lost_o
);

  localparam int SH_CNT_W    = $clog2(SH_CNT_MAX + 1);
  localparam int SH_INVLD_W  = $clog2(SH_INVLD_MAX + 1);
  localparam int SLIP_WAIT_W = $clog2(SLIP_WAIT_N + 1);

  localparam logic [SH_CNT_W-1:0]    SH_CNT_TC   = SH_CNT_MAX[SH_CNT_W-1:0];
  localparam logic [SH_INVLD_W-1:0]  SH_INVLD_TC = SH_INVLD_MAX[SH_INVLD_W-1:0];
  localparam logic [SLIP_WAIT_W-1:0] SLIP_LOAD   = SLIP_WAIT_N[SLIP_WAIT_W-1:0];
  localparam logic [SLIP_WAIT_W-1:0] SLIP_ONE    = {{(SLIP_WAIT_W-1){1'b0}}, 1'b1};

  lock_state_e             state_q;
  logic [SH_CNT_W-1:0]     sh_cnt_q,     sh_cnt_d;
  logic [SH_INVLD_W-1:0]   sh_invld_q,   sh_invld_d;
  logic [SLIP_WAIT_W-1:0]  slip_wait_q;
  logic                    slip_q, lock_q, lost_q;
  logic                    head_bad;
  logic                    do_slip;
  logic                    win_end;

  always_comb begin
    head_bad   = !sync_head_valid(serdes_head_i);
    sh_cnt_d   = sh_cnt_q + 1'b1;
    sh_invld_d = sh_invld_q + {{(SH_INVLD_W-1){1'b0}}, head_bad};
    // Unlocked: any bad header slips; locked: only when the window's bad-count hits the limit.
    do_slip    = head_bad && (!lock_q || (sh_invld_d == SH_INVLD_TC));
    win_end    = (sh_cnt_d == SH_CNT_TC);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= LOCK_TEST;
      sh_cnt_q    <= '0;
      sh_invld_q  <= '0;
      slip_wait_q <= '0;
      slip_q      <= 1'b0;
      lock_q      <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      slip_q <= 1'b0;
      lost_q <= 1'b0;
      if (serdes_v_i) begin
        case (state_q)
          LOCK_TEST: begin
            if (do_slip) begin
              slip_q      <= 1'b1;
              lost_q      <= lock_q;
              lock_q      <= 1'b0;
              sh_cnt_q    <= '0;
              sh_invld_q  <= '0;
              slip_wait_q <= SLIP_LOAD;
              state_q     <= LOCK_SLIP_WAIT;
            end else if (win_end) begin
              if (sh_invld_d == '0) begin
                lock_q <= 1'b1;
              end
              sh_cnt_q   <= '0;
              sh_invld_q <= '0;
            end else begin
              sh_cnt_q   <= sh_cnt_d;
              sh_invld_q <= sh_invld_d;
            end
          end
          LOCK_SLIP_WAIT: begin
            if (slip_wait_q <= SLIP_ONE) begin
              slip_wait_q <= '0;
              state_q     <= LOCK_TEST;
            end else begin
              slip_wait_q <= slip_wait_q - 1'b1;
            end
          end
          default: state_q <= LOCK_TEST;
        endcase
      end
    end
  end

  assign gearbox_slip_o = slip_q;
  assign lock_v_o       = lock_q;
  assign lock_lost_o    = lost_q;

endmodule
